// File: rtl/heavyhash_product_packer_pkg.sv
// Shared constants and types for the HeavyHash product packer.
// Contents: accumulator/nibble geometry, legal accumulation bound,
// packer FSM state type and the 256-bit hash word type.
package obtc_pkg;
   localparam int ACC_W   = 14;
   localparam int NIB_W   = 4;
   localparam int SHIFT   = 10;
   localparam int MAX_ACC = 14400;   // 64 * 15 * 15

   typedef enum logic [1:0] {IDLE, COLLECT, OUTPUT} packer_state_t;
   typedef logic [255:0] hash256_t;
endpackage

// File: rtl/heavyhash_product_packer_if.sv
// Handshake bundle between the PE array / SHA3 stages and the product packer.
// Ports (signals):
//   digest_in/digest_valid/digest_ready  SHA3 digest in
//   batch_in/batch_valid/batch_ready     NPE PE accumulations per beat
//   res_out/res_valid/res_ready          digest XOR product out
// Modports: slave = packer side, master = upstream/downstream side.
interface heavyhash_product_packer_if #(
   parameter int NPE   = 16,
   parameter int ACC_W = 14
);
   logic [255:0]         digest_in;
   logic                 digest_valid;
   logic                 digest_ready;
   logic [NPE*ACC_W-1:0] batch_in;
   logic                 batch_valid;
   logic                 batch_ready;
   logic [255:0]         res_out;
   logic                 res_valid;
   logic                 res_ready;

   modport slave (
      input  digest_in, digest_valid, batch_in, batch_valid, res_ready,
      output digest_ready, batch_ready, res_out, res_valid
   );

   modport master (
      output digest_in, digest_valid, batch_in, batch_valid, res_ready,
      input  digest_ready, batch_ready, res_out, res_valid
   );
endinterface

// File: rtl/heavyhash_product_packer_pe_nibble_slice.sv
// pe_nibble_slice: reduces one PE accumulation to its product nibble.
// Ports: acc (in, ACC_W) -> nib (out, 4) = acc[SHIFT+3:SHIFT];
//        ovf (out, 1) = acc > MAX_ACC, present only with PACKER_OVF_CHECK_EN.
// Purely combinational; no saturation on the data path.
module pe_nibble_slice #(
   parameter int ACC_W = 14,
   parameter int SHIFT = 10
) (
   input  logic [ACC_W-1:0]            acc,
`ifdef PACKER_OVF_CHECK_EN
   output logic                        ovf,
`endif
   output logic [obtc_pkg::NIB_W-1:0]  nib
);
   import obtc_pkg::*;

   assign nib = acc[SHIFT +: NIB_W];

`ifdef PACKER_OVF_CHECK_EN
   assign ovf = int'(acc) > MAX_ACC;
`else
   // Bits outside the nibble only matter for the range check.
   logic unused_acc_bits;
   assign unused_acc_bits = ^acc;
`endif
endmodule

// File: rtl/heavyhash_product_packer.sv
// heavyhash_product_packer: collects NROWS/NPE batches of PE accumulations,
// packs one nibble per row into a 256-bit product, XORs with the SHA3 digest
// and presents the registered result on a valid/ready handshake.
// Ports: clk, rst_n (sync, active-low), flush (sync abort),
//        bus (heavyhash_product_packer_if.slave), ovf_err (sticky range error).
// Optional feature macro: PACKER_OVF_CHECK_EN (accumulation range check).
//
// state   | meaning
// IDLE    | waiting for a digest
// COLLECT | accepting PE batches, filling the product register
// OUTPUT  | result valid and held until res_ready
module heavyhash_product_packer #(
   parameter int NPE   = 16,
   parameter int NROWS = 64,
   parameter int ACC_W = 14,
   parameter int SHIFT = 10
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        flush,
   heavyhash_product_packer_if.slave   bus,
   output logic                        ovf_err
);
   import obtc_pkg::*;

   localparam int NB    = NROWS / NPE;
   localparam int CNT_W = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CNT_W-1:0] LAST_B = CNT_W'(NB - 1);

   packer_state_t       state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   hash256_t            prod_q, prod_d;
   hash256_t            dig_q, dig_d;
   hash256_t            res_q, res_d;
   logic [NPE*NIB_W-1:0] nib_vec;
   logic                digest_fire, batch_fire, res_fire;
`ifdef PACKER_OVF_CHECK_EN
   logic [NPE-1:0]      ovf_vec;
   logic                ovf_q, ovf_d;
`endif

   for (genvar k = 0; k < NPE; k++) begin : g_slice
      pe_nibble_slice #(.ACC_W(ACC_W), .SHIFT(SHIFT)) u_slice (
         .acc (bus.batch_in[k*ACC_W +: ACC_W]),
`ifdef PACKER_OVF_CHECK_EN
         .ovf (ovf_vec[k]),
`endif
         .nib (nib_vec[k*NIB_W +: NIB_W])
      );
   end

   // A new digest may be taken in the same cycle the result is consumed.
   assign bus.digest_ready = (state_q == IDLE) || ((state_q == OUTPUT) && bus.res_ready);
   assign bus.batch_ready  = (state_q == COLLECT);
   assign bus.res_valid    = (state_q == OUTPUT);
   assign bus.res_out      = res_q;

   assign digest_fire = bus.digest_valid && bus.digest_ready;
   assign batch_fire  = bus.batch_valid  && bus.batch_ready;
   assign res_fire    = bus.res_valid    && bus.res_ready;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      prod_d  = prod_q;
      dig_d   = dig_q;
      res_d   = res_q;

      if (digest_fire) dig_d = bus.digest_in;

      // Row r lands in byte r/2, even rows in the high nibble: that is
      // nibble slot r^1 of the 256-bit word.
      if (batch_fire) begin
         for (int k = 0; k < NPE; k++) begin
            prod_d[NIB_W*((int'(cnt_q)*NPE + k) ^ 1) +: NIB_W] = nib_vec[k*NIB_W +: NIB_W];
         end
      end

      unique case (state_q)
         IDLE: begin
            if (digest_fire) state_d = COLLECT;
         end
         COLLECT: begin
            if (batch_fire) begin
               if (cnt_q == LAST_B) begin
                  state_d = OUTPUT;
                  cnt_d   = '0;
                  res_d   = dig_q ^ prod_d;   // includes the batch arriving now
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         OUTPUT: begin
            if (res_fire) state_d = digest_fire ? COLLECT : IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (flush) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         prod_q  <= '0;
         dig_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         prod_q  <= prod_d;
         dig_q   <= dig_d;
         res_q   <= res_d;
      end
   end

`ifdef PACKER_OVF_CHECK_EN
   // Sticky across flush; only reset clears it.
   always_comb ovf_d = ovf_q | (batch_fire & (|ovf_vec));

   always_ff @(posedge clk) begin
      if (!rst_n) ovf_q <= 1'b0;
      else        ovf_q <= ovf_d;
   end

   assign ovf_err = ovf_q;
`else
   assign ovf_err = 1'b0;
`endif
endmodule
